// File: rtl/sys_cmd_engine_pkg.sv
// Shared types for the system command engine: opcode byte values, FSM states and the ALU function code.
package sys_cmd_engine_pkg;

  localparam int unsigned ALU_FUN_W = 4;

  typedef logic [ALU_FUN_W-1:0] ALU_FUN_t;

  typedef enum logic [7:0] {
    OP_WR      = 8'hAA,
    OP_RD      = 8'hBB,
    OP_ALU     = 8'hCC,
    OP_ALU_FUN = 8'hDD,
    OP_BURST   = 8'hEE
  } cmd_op_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_GET_CNT,
    ST_GET_A,
    ST_GET_B,
    ST_GET_FUN,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_ALU_RUN,
    ST_TX_SEND
  } sys_cmd_state_t;

endpackage

// File: rtl/sys_cmd_tx_serializer.sv
// Response serialiser: loads a word plus byte count and pushes it LSB-first into the TX FIFO.
// The write strobe is gated by i_full_FIFO in the same cycle so no byte is ever written into a full FIFO.
module sys_cmd_tx_serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LOAD_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic [LOAD_WIDTH-1:0] i_data,
  input  logic [CNT_WIDTH-1:0]  i_nbytes,
  input  logic                  i_full_FIFO,
  output logic [DATA_WIDTH-1:0] o_TX_P_DATA,
  output logic                  o_TX_D_VLD,
  output logic                  o_done
);

  logic [LOAD_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_WIDTH-1:0]  left_q, left_d;
  logic                  done_q, done_d;
  logic                  send_c;

  assign send_c = (left_q != '0) && !i_full_FIFO;

  always_comb begin
    shreg_d = shreg_q;
    left_d  = left_q;
    done_d  = 1'b0;
    if (i_load) begin
      shreg_d = i_data;
      left_d  = i_nbytes;
    end else if (send_c) begin
      shreg_d = shreg_q >> DATA_WIDTH;
      left_d  = left_q - CNT_WIDTH'(1);
      done_d  = (left_q == CNT_WIDTH'(1));
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shreg_q <= '0;
      left_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      left_q  <= left_d;
      done_q  <= done_d;
    end
  end

  assign o_TX_P_DATA = shreg_q[DATA_WIDTH-1:0];
  assign o_TX_D_VLD  = send_c;
  assign o_done      = done_q;

endmodule

// File: rtl/sys_cmd_engine.sv
// System command engine: decodes RX command frames, drives register-file/ALU control, serialises responses.
// Optional inter-byte frame timeout is enabled by defining SYS_CMD_TIMEOUT_EN.
module sys_cmd_engine
  import sys_cmd_engine_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDRESS_BITS   = 4,
  parameter int unsigned ALU_OUT_WIDTH  = 16,
  parameter int unsigned ALU_FUN_WIDTH  = ALU_FUN_W,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [DATA_WIDTH-1:0]    i_RX_P_DATA,
  input  logic                     i_RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]    i_RdData,
  input  logic                     i_RdData_Valid,
  input  logic [ALU_OUT_WIDTH-1:0] i_ALU_OUT,
  input  logic                     i_OUT_VALID,
  input  logic                     i_full_FIFO,
  output logic [ADDRESS_BITS-1:0]  o_Address,
  output logic                     o_WrEn,
  output logic                     o_RdEn,
  output logic [DATA_WIDTH-1:0]    o_WrData,
  output ALU_FUN_t                 o_ALU_FUN,
  output logic                     o_Enable,
  output logic                     o_Clk_Enable,
  output logic [DATA_WIDTH-1:0]    o_TX_P_DATA,
  output logic                     o_TX_D_VLD,
  output logic                     o_clk_div_en,
  output logic                     o_cmd_err
);

  localparam int unsigned ALU_BYTES = ALU_OUT_WIDTH / DATA_WIDTH;
  localparam int unsigned BCNT_W    = $clog2(ALU_BYTES + 1);

  sys_cmd_state_t state_q, state_d;
  cmd_op_t        op_q, op_d;
  logic [DATA_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  ALU_FUN_t                alu_fun_q, alu_fun_d;
  logic wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic enable_q, enable_d, clk_en_q, clk_en_d;
  logic cmd_err_q, cmd_err_d, clk_div_en_q, clk_div_en_d;

  logic                     ser_load_c;
  logic [ALU_OUT_WIDTH-1:0] ser_data_c;
  logic [BCNT_W-1:0]        ser_nbytes_c;
  logic                     ser_done;
  logic [7:0]               opcode_c;
  logic                     in_get_c;
  logic                     timeout_c;

  assign opcode_c = i_RX_P_DATA[7:0];
  assign in_get_c = state_q inside {ST_GET_ADDR, ST_GET_DATA, ST_GET_CNT,
                                    ST_GET_A, ST_GET_B, ST_GET_FUN};

`ifdef SYS_CMD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counts idle cycles inside a frame; any accepted byte or leaving GET_* restarts it.
  always_comb begin
    tmo_d = '0;
    if (in_get_c && !i_RX_D_VLD) tmo_d = tmo_q + TMO_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end

  assign timeout_c = in_get_c && !i_RX_D_VLD && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  // Timeout disabled: frames may stall in GET_* indefinitely.
  assign timeout_c = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    alu_fun_d    = alu_fun_q;
    clk_en_d     = clk_en_q;
    clk_div_en_d = 1'b1;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    enable_d     = 1'b0;
    cmd_err_d    = 1'b0;
    ser_load_c   = 1'b0;
    ser_data_c   = '0;
    ser_nbytes_c = '0;

    if (timeout_c) begin
      state_d   = ST_IDLE;
      cmd_err_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: if (i_RX_D_VLD) begin
          case (opcode_c)
            OP_WR:      begin op_d = OP_WR;      state_d = ST_GET_ADDR; end
            OP_RD:      begin op_d = OP_RD;      state_d = ST_GET_ADDR; end
            OP_BURST:   begin op_d = OP_BURST;   state_d = ST_GET_ADDR; end
            OP_ALU:     begin op_d = OP_ALU;     state_d = ST_GET_A;    end
            OP_ALU_FUN: begin op_d = OP_ALU_FUN; state_d = ST_GET_FUN;  end
            default:    cmd_err_d = 1'b1;
          endcase
        end
        ST_GET_ADDR: if (i_RX_D_VLD) begin
          addr_d = i_RX_P_DATA[ADDRESS_BITS-1:0];
          case (op_q)
            OP_WR:    state_d = ST_GET_DATA;
            OP_BURST: state_d = ST_GET_CNT;
            default: begin
              cnt_d   = DATA_WIDTH'(1);
              state_d = ST_RD_REQ;
            end
          endcase
        end
        ST_GET_DATA: if (i_RX_D_VLD) begin
          wr_data_d = i_RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = ST_IDLE;
        end
        ST_GET_CNT: if (i_RX_D_VLD) begin
          cnt_d   = i_RX_P_DATA;
          state_d = (i_RX_P_DATA == '0) ? ST_IDLE : ST_RD_REQ;
        end
        ST_GET_A: if (i_RX_D_VLD) begin
          addr_d    = '0;
          wr_data_d = i_RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = ST_GET_B;
        end
        ST_GET_B: if (i_RX_D_VLD) begin
          addr_d    = ADDRESS_BITS'(1);
          wr_data_d = i_RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = ST_GET_FUN;
        end
        ST_GET_FUN: if (i_RX_D_VLD) begin
          alu_fun_d = ALU_FUN_t'(i_RX_P_DATA[ALU_FUN_WIDTH-1:0]);
          enable_d  = 1'b1;
          clk_en_d  = 1'b1;
          state_d   = ST_ALU_RUN;
        end
        ST_RD_REQ: begin
          rd_en_d = 1'b1;
          state_d = ST_RD_WAIT;
        end
        ST_RD_WAIT: if (i_RdData_Valid) begin
          ser_load_c   = 1'b1;
          ser_data_c   = ALU_OUT_WIDTH'(i_RdData);
          ser_nbytes_c = BCNT_W'(1);
          state_d      = ST_TX_SEND;
        end
        ST_ALU_RUN: if (i_OUT_VALID) begin
          ser_load_c   = 1'b1;
          ser_data_c   = i_ALU_OUT;
          ser_nbytes_c = BCNT_W'(ALU_BYTES);
          clk_en_d     = 1'b0;
          state_d      = ST_TX_SEND;
        end
        ST_TX_SEND: if (ser_done) begin
          // Reads and bursts loop back for the next register until the count is exhausted.
          if ((op_q == OP_RD || op_q == OP_BURST) && cnt_q != DATA_WIDTH'(1)) begin
            cnt_d   = cnt_q - DATA_WIDTH'(1);
            addr_d  = addr_q + ADDRESS_BITS'(1);
            state_d = ST_RD_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (i_RX_D_VLD && !in_get_c && state_q != ST_IDLE) cmd_err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_WR;
      cnt_q        <= '0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      alu_fun_q    <= '0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      enable_q     <= 1'b0;
      clk_en_q     <= 1'b0;
      cmd_err_q    <= 1'b0;
      clk_div_en_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      alu_fun_q    <= alu_fun_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      enable_q     <= enable_d;
      clk_en_q     <= clk_en_d;
      cmd_err_q    <= cmd_err_d;
      clk_div_en_q <= clk_div_en_d;
    end
  end

  sys_cmd_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH),
    .LOAD_WIDTH(ALU_OUT_WIDTH),
    .CNT_WIDTH (BCNT_W)
  ) u_tx_ser (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (ser_load_c),
    .i_data     (ser_data_c),
    .i_nbytes   (ser_nbytes_c),
    .i_full_FIFO(i_full_FIFO),
    .o_TX_P_DATA(o_TX_P_DATA),
    .o_TX_D_VLD (o_TX_D_VLD),
    .o_done     (ser_done)
  );

  assign o_Address    = addr_q;
  assign o_WrEn       = wr_en_q;
  assign o_RdEn       = rd_en_q;
  assign o_WrData     = wr_data_q;
  assign o_ALU_FUN    = alu_fun_q;
  assign o_Enable     = enable_q;
  assign o_Clk_Enable = clk_en_q;
  assign o_clk_div_en = clk_div_en_q;
  assign o_cmd_err    = cmd_err_q;

endmodule
